// File: rtl/riscv_mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package riscv_mdu_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_CNT_W = 5;

  localparam logic [ITER_CNT_W-1:0] ITER_LAST     = 5'd31;
  localparam logic [XLEN-1:0]       DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0]       INT_MIN       = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] val);
    return neg ? (~val + {{(XLEN-1){1'b0}}, 1'b1}) : val;
  endfunction

endpackage

// File: rtl/riscv_mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module riscv_mdu_div_step #(
  parameter int W = riscv_mdu_pkg::XLEN
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0]   shifted_s;
  logic [W-1:0] trial_s;
  logic         ge_s;

  // Partial remainder is always below the divisor, so the difference fits in W bits.
  always_comb begin
    shifted_s = {rem_in, quo_in[W-1]};
    ge_s      = (shifted_s >= {1'b0, divisor});
    trial_s   = shifted_s[W-1:0] - divisor;
    rem_out   = ge_s ? trial_s : shifted_s[W-1:0];
    quo_out   = {quo_in[W-2:0], ge_s};
  end

endmodule

// File: rtl/riscv_mdu_iterative.sv
// Iterative RV32M multiply/divide unit, one bit per cycle on operand magnitudes.
// Optional macro RISCV_MDU_EARLY_OUT_EN finishes trivial/special operands in one cycle.
module riscv_mdu_iterative #(
  parameter int XLEN       = riscv_mdu_pkg::XLEN,
  parameter bit ENABLE_MUL = 1'b1,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import riscv_mdu_pkg::*;

  mdu_state_e             state_r, state_s;
  mdu_op_e                op_r, op_in_s;
  logic [ITER_CNT_W-1:0]  cnt_r;
  logic [2*XLEN-1:0]      acc_r, acc_nxt_s, prod_fix_s;
  logic [XLEN-1:0]        opnd_r, result_r, result_s, final_s;
  logic [XLEN-1:0]        mag_a_s, mag_b_s, rem_nxt_s, quo_nxt_s;
  logic [XLEN:0]          mul_sum_s;
  logic                   neg_r, div_zero_r;
  logic                   load_s, iter_s, res_we_s;
  logic                   is_div_s, class_en_s, sgn_a_s, sgn_b_s, neg_in_s;

  // Operand decode: signedness per op, magnitudes and result-negate flag.
  always_comb begin
    op_in_s    = mdu_op_e'(op);
    is_div_s   = op[2];
    class_en_s = is_div_s ? ENABLE_DIV : ENABLE_MUL;
    case (op_in_s)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn_a_s = rs1[XLEN-1];
        sgn_b_s = rs2[XLEN-1];
      end
      OP_MULHSU: begin
        sgn_a_s = rs1[XLEN-1];
        sgn_b_s = 1'b0;
      end
      default: begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
      end
    endcase
    neg_in_s = (op_in_s == OP_REM) ? sgn_a_s : (sgn_a_s ^ sgn_b_s);
    mag_a_s  = neg_if(sgn_a_s, rs1);
    mag_b_s  = neg_if(sgn_b_s, rs2);
  end

  riscv_mdu_div_step #(.W(XLEN)) u_div_step (
    .rem_in  (acc_r[2*XLEN-1:XLEN]),
    .quo_in  (acc_r[XLEN-1:0]),
    .divisor (opnd_r),
    .rem_out (rem_nxt_s),
    .quo_out (quo_nxt_s)
  );

  // Datapath step plus the sign-fixed result of the step that would finish the op.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    prod_fix_s = {(2*XLEN){1'b0}};
    if (op_r[2]) begin
      acc_nxt_s = {rem_nxt_s, quo_nxt_s};
      if (op_r[1]) begin
        final_s = neg_if(neg_r, rem_nxt_s);
      end else if (div_zero_r) begin
        final_s = DIV_BY_ZERO_Q;
      end else begin
        final_s = neg_if(neg_r, quo_nxt_s);
      end
    end else begin
      acc_nxt_s  = {mul_sum_s, acc_r[XLEN-1:1]};
      prod_fix_s = neg_r ? (~acc_nxt_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_nxt_s;
      final_s    = (op_r[1:0] == 2'b00) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
    end
  end

`ifdef RISCV_MDU_EARLY_OUT_EN
  logic            early_s;
  logic [XLEN-1:0] early_res_s;

  // Results that need no iteration: divide by zero, signed overflow, zero operands.
  always_comb begin
    early_s     = 1'b0;
    early_res_s = {XLEN{1'b0}};
    if (is_div_s) begin
      if (rs2 == {XLEN{1'b0}}) begin
        early_s     = 1'b1;
        early_res_s = op[1] ? rs1 : DIV_BY_ZERO_Q;
      end else if (!op[0] && (rs1 == INT_MIN) && (rs2 == {XLEN{1'b1}})) begin
        early_s     = 1'b1;
        early_res_s = op[1] ? {XLEN{1'b0}} : INT_MIN;
      end else begin
        early_s     = (rs1 == {XLEN{1'b0}});
        early_res_s = {XLEN{1'b0}};
      end
    end else begin
      early_s     = (rs1 == {XLEN{1'b0}}) || (rs2 == {XLEN{1'b0}});
      early_res_s = {XLEN{1'b0}};
    end
  end
`endif

  // FSM next state, datapath enables and result write.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    iter_s   = 1'b0;
    res_we_s = 1'b0;
    result_s = result_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s = 1'b1;
          if (!class_en_s) begin
            state_s  = ST_DONE;
            res_we_s = 1'b1;
            result_s = {XLEN{1'b0}};
          end else begin
`ifdef RISCV_MDU_EARLY_OUT_EN
            if (early_s) begin
              state_s  = ST_DONE;
              res_we_s = 1'b1;
              result_s = early_res_s;
            end else begin
              state_s = ST_CALC;
            end
`else
            state_s = ST_CALC;
`endif
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (!start) begin
          state_s = ST_IDLE;
        end else begin
          iter_s = 1'b1;
          if (cnt_r == ITER_LAST) begin
            state_s  = ST_DONE;
            res_we_s = 1'b1;
            result_s = final_s;
          end else begin
            state_s = ST_CALC;
          end
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, operand latch, iteration state and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      op_r       <= OP_MUL;
      cnt_r      <= {ITER_CNT_W{1'b0}};
      acc_r      <= {(2*XLEN){1'b0}};
      opnd_r     <= {XLEN{1'b0}};
      neg_r      <= 1'b0;
      div_zero_r <= 1'b0;
      result_r   <= {XLEN{1'b0}};
    end else begin
      state_r <= state_s;
      if (res_we_s) begin
        result_r <= result_s;
      end
      if (load_s) begin
        op_r       <= op_in_s;
        cnt_r      <= {ITER_CNT_W{1'b0}};
        acc_r      <= {{XLEN{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
        opnd_r     <= is_div_s ? mag_b_s : mag_a_s;
        neg_r      <= neg_in_s;
        div_zero_r <= (rs2 == {XLEN{1'b0}});
      end else if (iter_s) begin
        acc_r <= acc_nxt_s;
        cnt_r <= cnt_r + 5'd1;
      end
    end
  end

  assign busy   = (state_r != ST_IDLE);
  assign done   = (state_r == ST_DONE);
  assign stall  = start & ~done;
  assign result = result_r;

endmodule

// File: tb/tb_riscv_mdu_iterative.sv
// Self-checking bench for riscv_mdu_iterative: arithmetic reference model plus cycle-level monitor.
module tb_riscv_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, stall, done;
  logic [31:0] result;

  int n_total = 0;
  int n_pass  = 0;

`ifdef RISCV_MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  riscv_mdu_iterative dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // RV32M result from plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        return 32'(sa % sb);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic bit special_ops(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2]) return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (a == 32'h0);
    return (a == 32'h0) || (b == 32'h0);
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return (EARLY && special_ops(o, a, b)) ? 1 : 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Cycle-level expectation: countdown to done, abort on dropped start.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_res = 32'h0, m_pend = 32'h0;
  int          m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= 32'h0; m_left <= 0;
    end else if (m_left != 0) begin
      if (!start) begin
        m_left <= 0; m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_left <= 0; m_done <= 1'b1; m_res <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0;
    end else if (start) begin
      m_busy <= 1'b1;
      if (exp_lat(op, rs1, rs2) == 1) begin
        m_done <= 1'b1; m_res <= ref_result(op, rs1, rs2);
      end else begin
        m_left <= 32; m_pend <= ref_result(op, rs1, rs2);
      end
    end else begin
      m_busy <= 1'b0;
    end
  end

  // Compare every cycle, just after the clock edge.
  always begin
    @(posedge clk);
    #1;
    chk("mon busy", 64'(busy), 64'(m_busy));
    chk("mon done", 64'(done), 64'(m_done));
    chk("mon result", 64'(result), 64'(m_res));
    chk("mon stall", 64'(stall), 64'(start & ~m_done));
  end

  // Hold start until done (bounded); called at a negedge, returns at the done negedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic [31:0] r);
    op = o; rs1 = a; rs2 = b; start = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 200);
    r = result;
    if (done !== 1'b1) begin
      n_total++;
      $display("FAIL issue timeout: op %0d no done after %0d cycles", o, n);
    end
  endtask

  task automatic directed(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e);
    int n;
    logic [31:0] r;
    chk({name, " model"}, 64'(ref_result(o, a, b)), 64'(e));
    issue(o, a, b, n, r);
    start = 1'b0;
    chk({name, " result"}, 64'(r), 64'(e));
    chk({name, " latency"}, 64'(n), 64'(exp_lat(o, a, b)));
    @(negedge clk);
  endtask

  initial begin
    int n, n2, k;
    logic [31:0] r, prior, a, b;
    logic [2:0] o;
    bit saw_done;

    rst_n = 1'b0; start = 1'b0; op = 3'd0; rs1 = 32'h0; rs2 = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    directed("MUL 7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    directed("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    directed("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    directed("DIV -20/3", 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
    directed("REM -20/3", 3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
    directed("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14);
    directed("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2);
    directed("DIVU 100/0", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF);
    directed("REMU 100/0", 3'd7, 32'd100, 32'd0, 32'd100);
    directed("DIV -7/0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    directed("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    directed("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Back-to-back with start held high across the done cycle.
    issue(3'd0, 32'd3, 32'd4, n, r);
    chk("b2b first result", 64'(r), 64'd12);
    chk("b2b first latency", 64'(n), 64'd33);
    rs1 = 32'd5; rs2 = 32'd6; n2 = n;
    do begin
      @(negedge clk);
      n2++;
    end while (done !== 1'b1 && n2 < 200);
    chk("b2b second result", 64'(result), 64'd30);
    chk("b2b second latency", 64'(n2), 64'd67);
    start = 1'b0;
    @(negedge clk);

    // Abort: drop start in CALC cycle 10.
    prior = result;
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort no done", 64'(saw_done), 64'd0);
    chk("abort result kept", 64'(result), 64'(prior));

    // Asynchronous reset mid-CALC.
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst result", 64'(result), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized operations, occasionally aborted.
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if ($urandom_range(0, 5) == 0) begin
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        k = $urandom_range(3, 20);
        repeat (k) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        issue(o, a, b, n, r);
        start = 1'b0;
        chk("rand result", 64'(r), 64'(ref_result(o, a, b)));
        chk("rand latency", 64'(n), 64'(exp_lat(o, a, b)));
        @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_mdu_iterative.md
Name: riscv_mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide unit, directly downstream of the single-cycle control decoder.
- Consumes the decoder's mdu_en and funct3 outputs as start/op, plus register-file operands rs1/rs2.
- Holds the core via stall until the result is ready, then drives result onto the writeback mux.
- Shift-add multiplier and restoring divider, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ENABLE_MUL, 1, when 0, MUL/MULH/MULHSU/MULHU complete with result 0.
- ENABLE_DIV, 1, when 0, DIV/DIVU/REM/REMU complete with result 0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  decoder mdu_en, qualified by instruction valid; level-held while core stalled
- op  in  3  decoder funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  operand A (dividend / multiplicand)
- rs2  in  XLEN  operand B (divisor / multiplier)
- busy  out  1  FSM not IDLE
- stall  out  1  start & ~done; freezes PC and register-file writes
- done  out  1  one-cycle pulse; result valid this cycle
- result  out  XLEN  registered result, held until next accepted start

Behaviour:
- Reset is asynchronous: state=IDLE; busy, done, result, counter, accumulators = 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE & start -> CALC. Latch op and operand magnitudes, record sign fixups (result negate flag per op signedness), counter=0.
  - CALC: one iteration per cycle; counter increments; after iteration 31, -> DONE.
  - CALC & ~start -> IDLE next cycle (flush/abort); no done, result unchanged.
  - DONE: done=1, result register valid; -> IDLE unconditionally.
  - start seen in DONE is ignored. The core retires the instruction on the done edge; the next MDU instruction is accepted in the following IDLE cycle.
- Latency: start sampled in IDLE at cycle N; CALC occupies N+1..N+32; done=1 at N+33.
- Multiply:
  - 64-bit product built from unsigned magnitudes, then two's-complement negated if signs differ.
  - Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- Divide:
  - Restoring, on magnitudes. Quotient is negated if signs differ; remainder takes the dividend's sign (truncating division).
- Boundary cases (RISC-V required values):
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
  - Without the optional feature, both cases still take the full 33-cycle path and produce these values.
- Disabled op class (ENABLE_* = 0): IDLE -> DONE directly, result = 0, done at N+1.
- result updates only on entry to DONE.

Optional Feature:
- Macro: RISCV_MDU_EARLY_OUT_EN.
- Defined: in IDLE, divide-by-zero, signed overflow, and any operand == 0 (multiply or dividend) go IDLE -> DONE. Result computed directly; done at N+1.
- Undefined: all enabled ops take the full 33-cycle path; results are identical either way.

Decomposition:
- Package riscv_mdu_pkg holds:
  - op enum (funct3 encodings above)
  - FSM state enum
  - XLEN constant
  - ITER_CNT_W = 5
  - constants DIV_BY_ZERO_Q = 0xFFFFFFFF and INT_MIN = 0x80000000
- One sub-module: riscv_mdu_div_step. Combinational single restoring step: shifts remainder/quotient, trial-subtracts divisor, outputs next remainder/quotient. Instantiated once in the FSM datapath.

Test Plan:
- MUL 7 × 0xFFFFFFFD, start at cycle 0 -> stall 1 for cycles 0..32, done at cycle 33, result 0xFFFFFFEB.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFEC / 3 -> 0xFFFFFFFA; REM same operands -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. With RISCV_MDU_EARLY_OUT_EN, each has done at cycle 1.
- Abort and reset:
  - Drop start at cycle 10 of CALC -> IDLE at cycle 11, no done pulse, result keeps prior value.
  - Assert rst_n=0 mid-CALC -> busy=0, result=0 immediately (asynchronous).
- Back-to-back MUL 3×4 then MUL 5×6 with start held high -> done pulses at cycles 33 and 67, results 12 then 30.
